// File: rtl/mix_columns_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mix_columns_pkg
// Description : Shared types, FSM encoding and GF(2^8) helper for the
//               sequential AES MixColumns block.
// Revision    : 1.0 - initial release
// ============================================================================
package mix_columns_pkg;

  // AES reduction polynomial x^8 + x^4 + x^3 + x + 1, low byte only
  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef logic [7:0] byte_t;

  // Byte 0 of a column sits in the most significant position
  typedef byte_t [0:3] column_t;

  // Column 0 sits in the most significant position, so byte k of the state
  // lands on bits [127-8k -: 8]
  typedef column_t [0:3] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    HOLD = 2'd2
  } fsm_t;

  // Multiply by x in GF(2^8)
  function automatic byte_t xtime(input byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

endpackage : mix_columns_pkg
`default_nettype wire

// File: rtl/mix_column.sv
`default_nettype none
// ============================================================================
// Module      : mix_column
// Description : Combinational MixColumns transform of a single AES column.
//               With MIX_COLUMNS_SEQ_INV_EN defined an extra 'inv' input
//               selects InvMixColumns.
// Revision    : 1.0 - initial release
// ============================================================================
module mix_column
  import mix_columns_pkg::*;
(
  input  column_t col_in,
`ifdef MIX_COLUMNS_SEQ_INV_EN
  input  logic    inv,
`endif
  output column_t col_out
);

  column_t fwd;

  // 3x = x ^ 2x
  function automatic byte_t mul3(input byte_t x);
    return x ^ xtime(x);
  endfunction

  // Forward matrix rows are rotations of {02,03,01,01}
  always_comb begin
    fwd[0] = xtime(col_in[0]) ^ mul3(col_in[1]) ^ col_in[2] ^ col_in[3];
    fwd[1] = col_in[0] ^ xtime(col_in[1]) ^ mul3(col_in[2]) ^ col_in[3];
    fwd[2] = col_in[0] ^ col_in[1] ^ xtime(col_in[2]) ^ mul3(col_in[3]);
    fwd[3] = mul3(col_in[0]) ^ col_in[1] ^ col_in[2] ^ xtime(col_in[3]);
  end

`ifdef MIX_COLUMNS_SEQ_INV_EN
  column_t invc;

  // Multiply by a 4-bit coefficient using x, 2x, 4x and 8x partial products
  function automatic byte_t mul_k(input byte_t x, input logic [3:0] k);
    byte_t x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? x : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  // Inverse matrix rows are rotations of {0E,0B,0D,09}
  always_comb begin
    invc[0] = mul_k(col_in[0], 4'hE) ^ mul_k(col_in[1], 4'hB) ^
              mul_k(col_in[2], 4'hD) ^ mul_k(col_in[3], 4'h9);
    invc[1] = mul_k(col_in[0], 4'h9) ^ mul_k(col_in[1], 4'hE) ^
              mul_k(col_in[2], 4'hB) ^ mul_k(col_in[3], 4'hD);
    invc[2] = mul_k(col_in[0], 4'hD) ^ mul_k(col_in[1], 4'h9) ^
              mul_k(col_in[2], 4'hE) ^ mul_k(col_in[3], 4'hB);
    invc[3] = mul_k(col_in[0], 4'hB) ^ mul_k(col_in[1], 4'hD) ^
              mul_k(col_in[2], 4'h9) ^ mul_k(col_in[3], 4'hE);
  end

  assign col_out = inv ? invc : fwd;
`else
  assign col_out = fwd;
`endif

endmodule : mix_column
`default_nettype wire

// File: rtl/mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module      : mix_columns_seq
// Description : Sequential AES MixColumns over a 128-bit state, processing
//               COLS_PER_CYCLE columns per clock, with a bypass path for the
//               final round and a valid/ready handshake on both sides.
//               Optional macro MIX_COLUMNS_SEQ_INV_EN adds the in_inv port
//               and the InvMixColumns datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module mix_columns_seq
  import mix_columns_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_bypass,
`ifdef MIX_COLUMNS_SEQ_INV_EN
  input  logic         in_inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Counter step truncates to 0 for 4 columns/cycle, so col stays at 0
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  fsm_t       state_q, state_d;
  logic [1:0] col_q;
  state_t     work_q, work_next;
  state_t     result_q;
  logic       accept;
  logic       last_step;
  column_t    mixed [COLS_PER_CYCLE];

`ifdef MIX_COLUMNS_SEQ_INV_EN
  logic inv_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid & in_ready;
  assign last_step = (state_q == MIX) && (col_q == LAST_COL);
  // Separate result register keeps out_state at the last completed result
  // while the working register is refilled with a new input
  assign out_state = result_q;

  for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_col
    logic [1:0] idx;
    assign idx = col_q + 2'(i);
    mix_column u_mix_column (
      .col_in  (work_q[idx]),
`ifdef MIX_COLUMNS_SEQ_INV_EN
      .inv     (inv_q),
`endif
      .col_out (mixed[i])
    );
  end

  // Working state with the current group of columns replaced in place
  always_comb begin
    work_next = work_q;
    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
      work_next[col_q + 2'(i)] = mixed[i];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: bypass goes straight to HOLD, mixing ends on the last column
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_bypass ? HOLD : MIX;
      MIX:     if (col_q == LAST_COL) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on handshake, mix in place, publish on completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work_q   <= '0;
      result_q <= '0;
      col_q    <= '0;
    end else if (accept) begin
      work_q <= in_state;
      col_q  <= '0;
      if (in_bypass) result_q <= in_state;
    end else if (state_q == MIX) begin
      work_q <= work_next;
      col_q  <= col_q + COL_STEP;
      if (last_step) result_q <= work_next;
    end
  end

`ifdef MIX_COLUMNS_SEQ_INV_EN
  // Direction select travels with the captured state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        inv_q <= 1'b0;
    else if (accept) inv_q <= in_inv;
  end
`endif

endmodule : mix_columns_seq
`default_nettype wire
